// File: rtl/vga_scan_generator_pkg.sv
// Shared raster timing defaults, RGB444 colour codes and pixel classification helpers
// for the Pong display path (scan generator, display controller, game logic).
// No ports: imported with "import vga_scan_generator_pkg::*;".
package vga_scan_generator_pkg;

  // 640x480@60 timing, in pixels / lines
  localparam int H_VISIBLE_DEF = 640;
  localparam int H_FRONT_DEF   = 16;
  localparam int H_SYNC_DEF    = 96;
  localparam int H_BACK_DEF    = 48;
  localparam int V_VISIBLE_DEF = 480;
  localparam int V_FRONT_DEF   = 10;
  localparam int V_SYNC_DEF    = 2;
  localparam int V_BACK_DEF    = 33;

  // RGB444 {R,G,B}
  localparam logic [11:0] COL_BG   = 12'h000;
  localparam logic [11:0] COL_FG   = 12'hFFF;
  localparam logic [11:0] COL_ALT  = 12'h888;
  localparam logic [11:0] COL_ALT2 = 12'h0F0;
  localparam logic [11:0] COL_ALT3 = 12'hF00;

  // One registered output pixel: sync, blanking and colour travel together.
  typedef struct packed {
    logic        hsync;
    logic        vsync;
    logic        videoOn;
    logic [11:0] rgb;
  } scanOut_t;

  // Inclusive range test on a 10-bit scan coordinate.
  function automatic logic inSpan(input logic [9:0] v, input logic [9:0] lo,
                                  input logic [9:0] hi);
    return (v >= lo) && (v <= hi);
  endfunction

  // Blanked pixels are forced black; otherwise altcol3 > altcol2 > altcol.
  function automatic logic [11:0] pickColour(input logic vis, input logic pixOn,
                                             input logic alt, input logic alt2,
                                             input logic alt3);
    if (!vis)   return 12'h000;
    if (!pixOn) return COL_BG;
    if (alt3)   return COL_ALT3;
    if (alt2)   return COL_ALT2;
    if (alt)    return COL_ALT;
    return COL_FG;
  endfunction

endpackage

// File: rtl/vga_scan_generator_frame_blinker.sv
// Frame-rate square wave: out toggles once every HALF_PERIOD tick pulses.
// Ports: clk, rst (sync, active-high), tick (one-clk frame pulse) -> out (registered flag).
// out toggles on the same clock edge that wraps the tick counter.
module frame_blinker #(
  parameter int HALF_PERIOD = 30
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  output logic out
);

  localparam int CntW = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(HALF_PERIOD - 1);

  logic [CntW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      out <= 1'b0;
    end else if (tick) begin
      if (cnt == CntLast) begin
        cnt <= '0;
        out <= ~out;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/vga_scan_generator.sv
// VGA raster generator for the Pong top level: scan counters out to the display
// controller, its pixel classification back in, registered pixel-aligned RGB/sync out.
// Ports: clk, rst (sync active-high); pixval/altcol/altcol2/altcol3 in; xpix/ypix,
//   hsync/vsync (active-low), rgb, video_on, frame_tick, gmv_flash, flick out.
module vga_scan_generator
  import vga_scan_generator_pkg::*;
#(
  parameter int H_VISIBLE    = H_VISIBLE_DEF,
  parameter int H_FRONT      = H_FRONT_DEF,
  parameter int H_SYNC       = H_SYNC_DEF,
  parameter int H_BACK       = H_BACK_DEF,
  parameter int V_VISIBLE    = V_VISIBLE_DEF,
  parameter int V_FRONT      = V_FRONT_DEF,
  parameter int V_SYNC       = V_SYNC_DEF,
  parameter int V_BACK       = V_BACK_DEF,
  parameter int PIX_DIV      = 2,
  parameter int FLASH_FRAMES = 30,
  parameter int FLICK_FRAMES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pixval,
  input  logic        altcol,
  input  logic        altcol2,
  input  logic        altcol3,
  output logic [9:0]  xpix,
  output logic [9:0]  ypix,
  output logic        hsync,
  output logic        vsync,
  output logic [11:0] rgb,
  output logic        video_on,
  output logic        frame_tick,
  output logic        gmv_flash,
  output logic        flick
);

  // Boundaries derived from the timing parameters, all 10-bit unsigned.
  localparam logic [9:0] HVis       = 10'(H_VISIBLE);
  localparam logic [9:0] VVis       = 10'(V_VISIBLE);
  localparam logic [9:0] HSyncStart = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] HSyncEnd   = 10'(H_VISIBLE + H_FRONT + H_SYNC - 1);
  localparam logic [9:0] VSyncStart = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] VSyncEnd   = 10'(V_VISIBLE + V_FRONT + V_SYNC - 1);
  localparam logic [9:0] HLast      = 10'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK - 1);
  localparam logic [9:0] VLast      = 10'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK - 1);

  localparam int DivW = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
  localparam logic [DivW-1:0] DivLast = DivW'(PIX_DIV - 1);

  logic [DivW-1:0] div;
  logic            pixEn;
  scanOut_t        nextOut;
  scanOut_t        outReg;
  logic            inVis;

  // With PIX_DIV=1 DivLast is 0, so div never leaves 0 and pixEn is always high.
  assign pixEn = (div == DivLast);

  always_ff @(posedge clk) begin
    if (rst || pixEn) div <= '0;
    else              div <= div + 1'b1;
  end

  // Stage 0: scan position seen by the display controller.
  always_ff @(posedge clk) begin
    if (rst) begin
      xpix <= '0;
      ypix <= '0;
    end else if (pixEn) begin
      if (xpix == HLast) begin
        xpix <= '0;
        ypix <= (ypix == VLast) ? 10'd0 : ypix + 10'd1;
      end else begin
        xpix <= xpix + 10'd1;
      end
    end
  end

  // Stage 1: classify the stage-0 position together with the controller's answer,
  // so sync and colour leave the block on the same edge.
  always_comb begin
    inVis           = (xpix < HVis) && (ypix < VVis);
    nextOut.hsync   = !inSpan(xpix, HSyncStart, HSyncEnd);
    nextOut.vsync   = !inSpan(ypix, VSyncStart, VSyncEnd);
    nextOut.videoOn = inVis;
    nextOut.rgb     = pickColour(inVis, pixval, altcol, altcol2, altcol3);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      outReg <= '{hsync: 1'b1, vsync: 1'b1, videoOn: 1'b0, rgb: 12'h000};
    end else if (pixEn) begin
      outReg <= nextOut;
    end
  end

  assign hsync    = outReg.hsync;
  assign vsync    = outReg.vsync;
  assign video_on = outReg.videoOn;
  assign rgb      = outReg.rgb;

  // Decoded from registers only; high for the single clk that ends the frame.
  assign frame_tick = pixEn && (xpix == HLast) && (ypix == VLast);

  frame_blinker #(.HALF_PERIOD(FLASH_FRAMES)) flashBlinker (
    .clk  (clk),
    .rst  (rst),
    .tick (frame_tick),
    .out  (gmv_flash)
  );

  frame_blinker #(.HALF_PERIOD(FLICK_FRAMES)) flickBlinker (
    .clk  (clk),
    .rst  (rst),
    .tick (frame_tick),
    .out  (flick)
  );

endmodule
